// File: rtl/dbg_capture_pkg.sv
// dbg_capture_pkg: capture-state encoding and shared constants for the debug capture mux
package dbg_capture_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } cap_state_t;
  localparam int CH_SEL_W = 8;
  localparam logic CH_OFF_BIT = 1'b0;
endpackage

// File: rtl/dbg_capture_ram.sv
// dbg_capture_ram: simple dual-port sample RAM, read-first, registered read data
// Ports: clk/rst_n clock and async active-low reset (read register only);
//   we/waddr/wdata write port; re/raddr read request; rdata registered read data (held when re is low).
module dbg_capture_ram #(
  parameter int W = 256,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // mem is updated by a non-blocking write, so a same-cycle read sees the old word
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/dbg_capture_mux.sv
// dbg_capture_mux: probe select, masked trigger and pre/post-trigger capture into a circular RAM
// Optional macro DBG_CAPTURE_TIMESTAMP_EN stores a free-running timestamp beside each sample.
// Ports: clk_100mhz/sys_rst_n clock and async active-low reset;
//   probe_bus/ch_sel probe source; arm/abort/trig_mask/trig_value/pre_trig capture control;
//   cap_state/done/trig_addr/start_addr capture status; rd_en/rd_addr/rd_data/rd_valid/rd_ts readout.
module dbg_capture_mux
  import dbg_capture_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DATA_W = 256,
  parameter int DEPTH = 1024,
  parameter int TS_W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk_100mhz,
  input  logic                   sys_rst_n,
  input  logic [N_CH*DATA_W-1:0] probe_bus,
  input  logic [CH_SEL_W-1:0]    ch_sel,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [DATA_W-1:0]      trig_mask,
  input  logic [DATA_W-1:0]      trig_value,
  input  logic [AW-1:0]          pre_trig,
  output logic [2:0]             cap_state,
  output logic                   done,
  output logic [AW-1:0]          trig_addr,
  output logic [AW-1:0]          start_addr,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [TS_W-1:0]        rd_ts
);
  cap_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, post_q, post_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d, start_addr_q, start_addr_d, cfg_pre_q, cfg_pre_d;
  logic [CH_SEL_W-1:0] cfg_ch_q, cfg_ch_d;
  logic [DATA_W-1:0] cfg_mask_q, cfg_mask_d, cfg_value_q, cfg_value_d, s_data_q, s_data_d;
  logic rd_valid_q, arm_ok, hit, we;
  // pre_trig is AW bits wide, so it can never exceed DEPTH-1 and is latched as-is
  always_comb begin
    arm_ok = arm && !abort && (state_q == IDLE || state_q == DONE);
    cfg_ch_d = arm_ok ? ch_sel : cfg_ch_q;
    cfg_mask_d = arm_ok ? trig_mask : cfg_mask_q;
    cfg_value_d = arm_ok ? trig_value : cfg_value_q;
    cfg_pre_d = arm_ok ? pre_trig : cfg_pre_q;
  end
  // select from the next-cycle channel so the first PRE sample already comes from the new channel
  always_comb begin
    s_data_d = {DATA_W{CH_OFF_BIT}};
    for (int k = 0; k < N_CH; k++)
      if (cfg_ch_d == CH_SEL_W'(k)) s_data_d = probe_bus[k*DATA_W +: DATA_W];
  end
  assign hit = ((s_data_q ^ cfg_value_q) & cfg_mask_q) == '0;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d = cnt_q;
    post_d = post_q;
    trig_addr_d = trig_addr_q;
    start_addr_d = start_addr_q;
    we = 1'b0;
    unique case (state_q)
      PRE: begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == cfg_pre_q - 1'b1) ? WAIT : PRE;
      end
      WAIT: begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (hit) begin
          trig_addr_d = wr_ptr_q;
          start_addr_d = wr_ptr_q - cfg_pre_q;
          post_d = {AW{1'b1}} - cfg_pre_q;
          state_d = (post_d == '0) ? DONE : POST;
        end
      end
      POST: begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        post_d = post_q - 1'b1;
        state_d = (post_q == AW'(1)) ? DONE : POST;
      end
      default: ;
    endcase
    if (arm_ok) begin
      wr_ptr_d = '0;
      cnt_d = '0;
      state_d = (cfg_pre_d == '0) ? WAIT : PRE;
    end
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk_100mhz or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      post_q <= '0;
      trig_addr_q <= '0;
      start_addr_q <= '0;
      cfg_pre_q <= '0;
      cfg_ch_q <= '0;
      cfg_mask_q <= '0;
      cfg_value_q <= '0;
      s_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q <= cnt_d;
      post_q <= post_d;
      trig_addr_q <= trig_addr_d;
      start_addr_q <= start_addr_d;
      cfg_pre_q <= cfg_pre_d;
      cfg_ch_q <= cfg_ch_d;
      cfg_mask_q <= cfg_mask_d;
      cfg_value_q <= cfg_value_d;
      s_data_q <= s_data_d;
      rd_valid_q <= rd_en;
    end
`ifdef DBG_CAPTURE_TIMESTAMP_EN
  localparam int RAM_W = DATA_W + TS_W;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [RAM_W-1:0] wdata, rdata;
  assign ts_d = ts_q + 1'b1;
  always_ff @(posedge clk_100mhz or negedge sys_rst_n)
    if (!sys_rst_n) ts_q <= '0;
    else ts_q <= ts_d;
  assign wdata = {ts_q, s_data_q};
  assign rd_data = rdata[DATA_W-1:0];
  assign rd_ts = rdata[DATA_W +: TS_W];
`else
  localparam int RAM_W = DATA_W;
  logic [RAM_W-1:0] wdata, rdata;
  assign wdata = s_data_q;
  assign rd_data = rdata;
  assign rd_ts = '0;
`endif
  dbg_capture_ram #(.W(RAM_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk_100mhz),
    .rst_n(sys_rst_n),
    .we(we),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .re(rd_en),
    .raddr(rd_addr),
    .rdata(rdata)
  );
  assign cap_state = state_q;
  assign done = state_q == DONE;
  assign trig_addr = trig_addr_q;
  assign start_addr = start_addr_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_dbg_capture_mux.sv
// tb_dbg_capture_mux: directed capture scenarios with a read-data scoreboard
module tb_dbg_capture_mux;
  localparam int N_CH = 4, DATA_W = 32, DEPTH = 16, AW = 4, TS_W = 32;
  logic clk_100mhz = 1'b0, sys_rst_n = 1'b0;
  logic [N_CH*DATA_W-1:0] probe_bus;
  logic [7:0] ch_sel;
  logic arm, abort, done, rd_en, rd_valid;
  logic [DATA_W-1:0] trig_mask, trig_value, rd_data;
  logic [AW-1:0] pre_trig, trig_addr, start_addr, rd_addr;
  logic [2:0] cap_state;
  logic [TS_W-1:0] rd_ts;
  logic [DATA_W-1:0] ch2;
  logic [DATA_W-1:0] sb_q[$];
  int checks = 0, errors = 0;
  always #5 clk_100mhz = ~clk_100mhz;
  assign probe_bus = {32'hDEAD_0003, ch2, 32'hDEAD_0001, 32'hDEAD_0000};
  dbg_capture_mux #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .probe_bus(probe_bus), .ch_sel(ch_sel),
    .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value), .pre_trig(pre_trig),
    .cap_state(cap_state), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ts(rd_ts)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  initial begin
    ch2 = '0;
    forever begin
      @(negedge clk_100mhz);
      ch2 = ch2 + 1;
    end
  end
  logic ts_seq = 1'b0, ts_have = 1'b0;
  logic [TS_W-1:0] ts_prev;
  initial begin
    logic en_prev;
    logic [DATA_W-1:0] exp;
    forever begin
      @(posedge clk_100mhz);
      en_prev = rd_en;
      #1;
      if (rd_valid || en_prev) chk("rd_valid_mirror", rd_valid, en_prev);
      if (rd_valid) begin
        if (sb_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else begin
          exp = sb_q.pop_front();
          chk("rd_data", rd_data, exp);
        end
`ifdef DBG_CAPTURE_TIMESTAMP_EN
        if (ts_seq) begin
          if (ts_have) chk("rd_ts_increasing", rd_ts > ts_prev, 1);
          ts_prev = rd_ts;
          ts_have = 1'b1;
        end
`else
        chk("rd_ts_zero", rd_ts, 0);
`endif
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DATA_W-1:0] exp);
    rd_en = 1'b1;
    rd_addr = a;
    sb_q.push_back(exp);
    tick(1);
    rd_en = 1'b0;
  endtask
  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask
  task automatic wait_done(output int post_cyc);
    post_cyc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(1);
      if (cap_state == 3'd3) post_cyc++;
    end
    chk("done_reached", done, 1);
  endtask
  initial begin
    int pc;
    logic [DATA_W-1:0] v;
    arm = 0; abort = 0; rd_en = 0; rd_addr = '0; ch_sel = '0;
    trig_mask = '0; trig_value = '0; pre_trig = '0;
    tick(3);
    chk("rst_state", cap_state, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    sys_rst_n = 1'b1;
    tick(2);
    // incrementing channel 2, trigger on 100 with 4 pre-trigger samples
    ch_sel = 8'd2; trig_mask = '1; trig_value = 32'd100; pre_trig = 4'd4;
    pulse_arm();
    chk("t1_pre_state", cap_state, 1);
    wait_done(pc);
    chk("t1_post_cycles", pc, 11);
    chk("t1_start_addr", start_addr, AW'(trig_addr - 4'd4));
    ts_seq = 1'b1;
    for (int i = 0; i < DEPTH; i++) rd(start_addr + AW'(i), 32'd96 + i);
    tick(2);
    ts_seq = 1'b0;
    rd(trig_addr, 32'd100);
    for (int j = 0; j < 8; j++) begin
      int i;
      i = $urandom_range(0, DEPTH - 1);
      rd(start_addr + AW'(i), 32'd96 + i);
      if (j % 2 == 1) tick(1);
    end
    tick(2);
    // out-of-range channel reads as zero: immediate hit with value 0
    ch_sel = 8'd7; trig_mask = 32'h1; trig_value = 32'h0; pre_trig = 4'd0;
    pulse_arm();
    chk("t2_wait_state", cap_state, 2);
    tick(1);
    chk("t2_post_state", cap_state, 3);
    chk("t2_trig_addr", trig_addr, 0);
    chk("t2_start_addr", start_addr, 0);
    wait_done(pc);
    rd(4'd5, 32'h0);
    rd(4'd15, 32'h0);
    tick(2);
    // value 1 can never match all-zero data
    trig_value = 32'h1;
    pulse_arm();
    chk("t2b_wait_state", cap_state, 2);
    tick(40);
    chk("t2b_still_wait", cap_state, 2);
    chk("t2b_no_done", done, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t2b_abort_idle", cap_state, 0);
    // maximum pre-trigger: trigger sample is the last write, no POST phase
    ch_sel = 8'd2; trig_mask = '1; pre_trig = 4'd15;
    v = ch2 + 40;
    trig_value = v;
    pulse_arm();
    chk("t3_pre_state", cap_state, 1);
    wait_done(pc);
    chk("t3_post_cycles", pc, 0);
    chk("t3_start_addr", start_addr, AW'(trig_addr + 4'd1));
    rd(trig_addr, v);
    for (int i = 0; i < DEPTH; i++) rd(start_addr + AW'(i), v - 15 + i);
    tick(2);
    // abort together with arm during POST
    ch_sel = 8'd0; trig_mask = '0; trig_value = '0; pre_trig = 4'd2;
    pulse_arm();
    chk("t4_pre_state", cap_state, 1);
    tick(3);
    chk("t4_post_state", cap_state, 3);
    chk("t4_trig_addr", trig_addr, 2);
    abort = 1'b1; arm = 1'b1;
    tick(1);
    abort = 1'b0; arm = 1'b0;
    chk("t4_abort_idle", cap_state, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_trig_hold", trig_addr, 2);
    chk("t4_start_hold", start_addr, 0);
    pulse_arm();
    chk("t4_rearm_pre", cap_state, 1);
    wait_done(pc);
    chk("t4_post_cycles", pc, 13);
    rd(4'd2, 32'hDEAD_0000);
    tick(2);
    // asynchronous reset while waiting
    ch_sel = 8'd7; trig_mask = 32'h1; trig_value = 32'h1; pre_trig = 4'd0;
    pulse_arm();
    tick(3);
    chk("t6_wait_state", cap_state, 2);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_state", cap_state, 0);
    chk("t6_rst_trig_addr", trig_addr, 0);
    chk("t6_rst_start_addr", start_addr, 0);
    chk("t6_rst_rd_data", rd_data, 0);
    chk("t6_rst_rd_valid", rd_valid, 0);
    tick(1);
    sys_rst_n = 1'b1;
    tick(5);
    chk("t6_idle_after_rst", cap_state, 0);
    chk("t6_no_done", done, 0);
    tick(2);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
